decoder_2: RTL and testbench
============================

# decoder_2

Registered binary-to-one-hot decoder with enable. A 2-bit select `in` is decoded into a 4-bit one-hot `out` when `EN` is high. With `EN` low, `out` is all zeros. It sits between control logic and per-target enable lines (chip selects, mux selects), so its output is registered and glitch-free.

## Interface
- `IN_W`, default 2: select width. Supported range 1..4.
- `OUT_W`, derived as 2**IN_W (4 by default): output width. Local, not overridable.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in` input, IN_W bits: binary select.
- `EN` input, 1 bit: decode enable, active-high.
- `out` output, OUT_W bits: registered one-hot decode. Bit `in` is set when enabled.
- `active` output, 1 bit: registered; high when `out` is non-zero.

## Operation
- Combinational next value:
  - `EN`=1: `nxt = 1 << in`, exactly one bit set.
  - `EN`=0: `nxt = 0`.
- On each rising `clk`: `out <= nxt` and `active <= EN`.
- Mapping at IN_W=2 with EN=1:
  - 00 -> 0001
  - 01 -> 0010
  - 10 -> 0100
  - 11 -> 1000
- Invariant: `out` is either all-zero or one-hot. It never has more than one bit set.
- `active` always equals the OR-reduction of `out`. Both come from the same edge, so they never disagree.
- `in` is don't-care while `EN`=0. It has no effect on any output.
- No internal state besides the output registers. No state machine.

## Timing
- Reset:
  - Asserting `rst_n` low immediately forces `out`=0 and `active`=0, independent of `clk`.
  - Outputs stay 0 while `rst_n` is low.
- Release: the first rising edge with `rst_n` high loads the decode of the current `in`/`EN`.
- Latency: exactly 1 clock from `in`/`EN` change (sampled at an edge) to `out`.
- Throughput: a new select is accepted every cycle, with no handshake.
- `EN` falling: `out` becomes 0 on the next edge (cleared, not held).
- Select changing while `EN` stays high: `out` moves directly from the old one-hot to the new one-hot in one edge. There is no zero cycle and no two-hot cycle.
- Reset mid-operation: outputs clear asynchronously. Operation resumes from the sampled inputs on the first edge after release.
- Inputs must meet setup/hold to `clk`. There is no synchronizer inside.

## Configuration
- Macro: `DECODER_2_HOLD_EN`.
- Defined:
  - While `EN`=0, `out` and `active` hold their last registered values instead of clearing.
  - Reset still clears both to 0.
  - After reset with `EN` never asserted, `out` remains 0.
- Not defined:
  - `EN`=0 clears `out` to 0 on the next edge, as described in Operation.
- No other behaviour changes.

## Test plan
- Reset: hold `rst_n`=0 with `EN`=1, `in`=11 and clock running -> `out`=0000, `active`=0 throughout. Assert `rst_n` low mid-cycle after `out`=1000 -> `out`=0000 immediately, before the next edge.
- Full sweep: `EN`=1, drive `in`=00, 01, 10, 11 on successive cycles -> `out`=0001, 0010, 0100, 1000 each one cycle later, `active`=1.
- Disable: from `in`=11 with `out`=1000, drop `EN` to 0 -> next edge `out`=0000, `active`=0. With `DECODER_2_HOLD_EN` defined -> `out` stays 1000, `active` stays 1.
- Don't-care: `EN`=0, toggle `in` through all values -> `out` is constant (0000 default).
- Back-to-back: `EN`=1, alternate `in` 00/11 every cycle -> `out` alternates 0001/1000 with no intermediate value. The one-hot/zero invariant is checked every cycle.
- Parameter: IN_W=3, `EN`=1, `in`=101 -> `out`=00100000 one cycle later.

Source files
------------

// File: rtl/decoder_2.sv
// ============================================================================
// Module   : decoder_2
// Purpose  : Registered binary-to-one-hot decoder with enable. Optional macro
//            DECODER_2_HOLD_EN makes outputs hold (rather than clear) while
//            EN is low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_2 #(
    parameter int IN_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       in,
    input  logic                  EN,
    output logic [(2**IN_W)-1:0]  out,
    output logic                  active
);

    localparam int OUT_W = 2**IN_W;

    logic [OUT_W-1:0] nxt;

    // Exactly one bit set when enabled, so out is always zero or one-hot.
    always_comb begin
        nxt = '0;
        if (EN) begin
            nxt = OUT_W'(1) << in;
        end
    end

`ifdef DECODER_2_HOLD_EN
    // Outputs are only loaded while enabled; a low EN freezes the last decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out    <= '0;
            active <= 1'b0;
        end else if (EN) begin
            out    <= nxt;
            active <= 1'b1;
        end
    end
`else
    // active is registered from EN on the same edge as out, so it always
    // matches the OR-reduction of out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out    <= '0;
            active <= 1'b0;
        end else begin
            out    <= nxt;
            active <= EN;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoder_2.sv
// Self-checking bench for decoder_2: directed tests plus randomized stimulus
// against a behavioural model, for IN_W=2 and IN_W=3 instances.
`default_nettype none

module tb_decoder_2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sel = '0;
    logic       en = 1'b0;
    logic [3:0] dout;
    logic       act;

    logic [2:0] sel3 = '0;
    logic       en3 = 1'b0;
    logic [7:0] dout3;
    logic       act3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_out  = '0;
    logic       exp_act  = 1'b0;
    logic [7:0] exp_out3 = '0;
    logic       exp_act3 = 1'b0;

    always #5 clk = ~clk;

    decoder_2 #(.IN_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in(sel), .EN(en), .out(dout), .active(act)
    );

    decoder_2 #(.IN_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in(sel3), .EN(en3), .out(dout3), .active(act3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: what a registered one-hot decoder shows after one edge.
    task automatic model_edge();
        if (!rst_n) begin
            exp_out = '0; exp_act = 1'b0; exp_out3 = '0; exp_act3 = 1'b0;
        end else begin
`ifdef DECODER_2_HOLD_EN
            if (en)  exp_out  = 4'(2 ** int'(sel));
            if (en3) exp_out3 = 8'(2 ** int'(sel3));
`else
            exp_out  = en  ? 4'(2 ** int'(sel))  : 4'd0;
            exp_out3 = en3 ? 8'(2 ** int'(sel3)) : 8'd0;
`endif
            exp_act  = (exp_out  != 0);
            exp_act3 = (exp_out3 != 0);
        end
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".out"},     32'(dout),  32'(exp_out));
        check({tag, ".active"},  32'(act),   32'(exp_act));
        check({tag, ".onehot"},  32'($countones(dout) <= 1), 32'd1);
        check({tag, ".out3"},    32'(dout3), 32'(exp_out3));
        check({tag, ".active3"}, 32'(act3),  32'(exp_act3));
    endtask

    initial begin
        // Reset held with decode requested: outputs must stay zero.
        rst_n = 1'b0; en = 1'b1; sel = 2'b11; en3 = 1'b1; sel3 = 3'd7;
        for (int i = 0; i < 3; i++) cycle("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Full sweep with fixed expected patterns.
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            cycle("sweep");
        end
        check("sweep.last", 32'(dout), 32'h8);

        // Parameterized instance: 101 -> 00100000.
        sel3 = 3'b101; en3 = 1'b1;
        cycle("inw3");
        check("inw3.fixed", 32'(dout3), 32'h20);

        // Disable from 1000.
        sel = 2'b11; en = 1'b1;
        cycle("pre_disable");
        en = 1'b0;
        cycle("disable");
`ifdef DECODER_2_HOLD_EN
        check("disable.fixed", 32'(dout), 32'h8);
`else
        check("disable.fixed", 32'(dout), 32'h0);
`endif

        // Select is a don't-care while disabled.
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            cycle("dontcare");
        end

        // Back-to-back alternation 00/11.
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sel = (i % 2 == 0) ? 2'b00 : 2'b11;
            cycle("b2b");
        end

        // Asynchronous reset mid-cycle after out=1000.
        sel = 2'b11; en = 1'b1;
        cycle("pre_areset");
        check("pre_areset.fixed", 32'(dout), 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check("areset.out", 32'(dout), 32'h0);
        check("areset.active", 32'(act), 32'h0);
        exp_out = '0; exp_act = 1'b0; exp_out3 = '0; exp_act3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_areset");

        // Randomized stimulus against the model.
        for (int i = 0; i < 300; i++) begin
            sel  = 2'($urandom);
            en   = ($urandom_range(0, 3) != 0);
            sel3 = 3'($urandom);
            en3  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                check("rand_areset.out", 32'(dout), 32'h0);
                exp_out = '0; exp_act = 1'b0; exp_out3 = '0; exp_act3 = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
